data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory requests: services MemRead/MemWrite from the controller's stage-3 decode (load/store), with configurable wait states.
- Holds a DEPTH x DATA_W register-array data memory.
- Returns read data with a one-cycle MemReady pulse.
- Drives Stall so the pipeline (PCwrite, IRload, IR3load, IR4load, R1R2Load, WBWrite) freezes while an access is outstanding.

---
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the pipeline controller (master)
// and the memory responder (slave).
//   MemRead/MemWrite : request strobes, held by the master until MemReady
//   Addr/MemIn       : access address and write data
//   MemOut           : read data, valid with MemReady and held afterwards
//   MemReady         : one-cycle completion pulse
//   Stall            : pipeline freeze request
//   Busy             : responder is in WAIT or DONE
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] MemIn;
  logic [DATA_W-1:0] MemOut;
  logic              MemReady;
  logic              Stall;
  logic              Busy;

  modport master (
    output MemRead, MemWrite, Addr, MemIn,
    input  MemOut, MemReady, Stall, Busy
  );

  modport slave (
    input  MemRead, MemWrite, Addr, MemIn,
    output MemOut, MemReady, Stall, Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for pipeline data-memory requests (loads/stores).
// Holds a DEPTH x DATA_W register-array memory and completes each access
// WAIT_CYCLES+1 cycles after acceptance with a one-cycle MemReady pulse.
// Stall freezes the pipeline while an access is outstanding.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (memory contents are kept)
//   bus   : data_mem_responder_if slave modport (see interface header)
//
// Optional feature, macro DATA_MEM_LASTHIT_EN: a one-entry last-access tag lets
// a read that hits it complete one cycle after acceptance.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              hit;
  logic              enter_done;
  logic              mem_we;
  // Access operands: live bus values when accepting from IDLE (zero-wait or
  // tag hit go straight to DONE), latched copies otherwise.
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_wr;

`ifdef DATA_MEM_LASTHIT_EN
  logic              tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic [DATA_W-1:0] tag_data_q, tag_data_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    out_d    = out_q;
    hit      = 1'b0;
    acc_addr = addr_q;
    acc_data = data_q;
    acc_wr   = wr_q;
    req      = bus.MemRead | bus.MemWrite;
`ifdef DATA_MEM_LASTHIT_EN
    tag_valid_d = tag_valid_q;
    tag_addr_d  = tag_addr_q;
    tag_data_d  = tag_data_q;
`endif

    unique case (state_q)
      StIdle: begin
        acc_addr = bus.Addr;
        acc_data = bus.MemIn;
        acc_wr   = bus.MemWrite;
        if (req) begin
          addr_d = bus.Addr;
          data_d = bus.MemIn;
          wr_d   = bus.MemWrite;
          cnt_d  = WaitInit;
`ifdef DATA_MEM_LASTHIT_EN
          hit = !bus.MemWrite && tag_valid_q && (bus.Addr == tag_addr_q);
`endif
          state_d = (hit || WAIT_CYCLES == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    enter_done = (state_d == StDone) && (state_q != StDone);
    mem_we     = enter_done && acc_wr;

    if (enter_done && !acc_wr) begin
      out_d = mem[acc_addr];
`ifdef DATA_MEM_LASTHIT_EN
      if (hit) out_d = tag_data_q;
`endif
    end

`ifdef DATA_MEM_LASTHIT_EN
    if (enter_done) begin
      tag_valid_d = 1'b1;
      tag_addr_d  = acc_addr;
      tag_data_d  = acc_wr ? acc_data : out_d;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      out_q   <= out_d;
    end
  end

`ifdef DATA_MEM_LASTHIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
      tag_data_q  <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_addr_q  <= tag_addr_d;
      tag_data_q  <= tag_data_d;
    end
  end
`endif

  // Memory array is deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[acc_addr] <= acc_data;
  end

  assign bus.MemOut   = out_q;
  assign bus.MemReady = (state_q == StDone);
  assign bus.Stall    = ((state_q == StIdle) && req) || (state_q == StWait);
  assign bus.Busy     = (state_q == StWait) || (state_q == StDone);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic       clock;
  logic       reset;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] addr;
  logic [7:0] mem_in;
  int         sel;

  int errors;
  int checks;

  logic [7:0] obs_out;
  logic       obs_ready;
  logic       obs_stall;
  logic       obs_busy;

  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();
  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

  assign bus0.MemRead  = mem_read & (sel == 0);
  assign bus0.MemWrite = mem_write & (sel == 0);
  assign bus0.Addr     = addr;
  assign bus0.MemIn    = mem_in;
  assign bus2.MemRead  = mem_read & (sel == 2);
  assign bus2.MemWrite = mem_write & (sel == 2);
  assign bus2.Addr     = addr;
  assign bus2.MemIn    = mem_in;
  assign bus3.MemRead  = mem_read & (sel == 3);
  assign bus3.MemWrite = mem_write & (sel == 3);
  assign bus3.Addr     = addr;
  assign bus3.MemIn    = mem_in;

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  data_mem_responder #(.WAIT_CYCLES(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  data_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

  always_comb begin
    obs_out   = bus2.MemOut;
    obs_ready = bus2.MemReady;
    obs_stall = bus2.Stall;
    obs_busy  = bus2.Busy;
    if (sel == 0) begin
      obs_out   = bus0.MemOut;
      obs_ready = bus0.MemReady;
      obs_stall = bus0.Stall;
      obs_busy  = bus0.Busy;
    end else if (sel == 3) begin
      obs_out   = bus3.MemOut;
      obs_ready = bus3.MemReady;
      obs_stall = bus3.Stall;
      obs_busy  = bus3.Busy;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on DUT s and follow it to completion.
  task automatic access(input int s, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int exp_lat, input bit chk_out,
                        input logic [7:0] exp_out, input string tag);
    int  cyc;
    bit  seen;
    sel       = s;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    mem_in    = d;
    #1;
    chk({tag, "_stall_req"}, 32'(obs_stall), 32'd1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
      if (obs_ready) seen = 1;
      else chk({tag, "_stall_wait"}, 32'(obs_stall), 32'd1);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_stall_done"}, 32'(obs_stall), 32'd0);
    chk({tag, "_busy_done"}, 32'(obs_busy), 32'd1);
    if (chk_out) chk({tag, "_memout"}, 32'(obs_out), 32'(exp_out));
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clock);
    #1;
    chk({tag, "_ready_pulse"}, 32'(obs_ready), 32'd0);
    chk({tag, "_stall_after"}, 32'(obs_stall), 32'd0);
  endtask

  initial begin
    int lat_hit;
    errors    = 0;
    checks    = 0;
    sel       = 2;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    mem_in    = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("idle_memout", 32'(obs_out), 32'h00);
      chk("idle_ready", 32'(obs_ready), 32'd0);
      chk("idle_stall", 32'(obs_stall), 32'd0);
      chk("idle_busy", 32'(obs_busy), 32'd0);
    end

    // Write then read, two wait states.
    access(2, 0, 1, 8'h3C, 8'hA5, 3, 0, 8'h00, "w2_3c");
    chk("w2_memout_kept", 32'(obs_out), 32'h00);
    access(2, 1, 0, 8'h3C, 8'h00, 3, 1, 8'hA5, "r2_3c");

    // Zero wait states at the top address.
    sel = 0;
    access(0, 0, 1, 8'hFF, 8'h7E, 1, 0, 8'h00, "w0_ff");
    access(0, 1, 0, 8'hFF, 8'h00, 1, 1, 8'h7E, "r0_ff");

    // Simultaneous read+write acts as a write; MemOut keeps prior read data.
    access(2, 0, 1, 8'h40, 8'h11, 3, 0, 8'h00, "w2_40");
    access(2, 1, 0, 8'h40, 8'h00, 3, 1, 8'h11, "r2_40");
    access(2, 1, 1, 8'h10, 8'h55, 3, 1, 8'h11, "rw2_10");
    access(2, 1, 0, 8'h10, 8'h00, 3, 1, 8'h55, "r2_10");

    // Reset during WAIT of a write aborts it.
    access(2, 0, 1, 8'h20, 8'h44, 3, 0, 8'h00, "w2_20_old");
    sel       = 2;
    mem_write = 1'b1;
    addr      = 8'h20;
    mem_in    = 8'h99;
    @(posedge clock);
    #1;
    chk("abort_busy_before", 32'(obs_busy), 32'd1);
    mem_write = 1'b0;
    reset     = 1'b1;
    #1;
    chk("abort_memout", 32'(obs_out), 32'h00);
    chk("abort_ready", 32'(obs_ready), 32'd0);
    chk("abort_stall", 32'(obs_stall), 32'd0);
    chk("abort_busy", 32'(obs_busy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    access(2, 1, 0, 8'h20, 8'h00, 3, 1, 8'h44, "r2_20");

    // Three wait states; last-hit tag shortens a repeated read when enabled.
`ifdef DATA_MEM_LASTHIT_EN
    lat_hit = 1;
`else
    lat_hit = 4;
`endif
    access(3, 0, 1, 8'h08, 8'h5A, 4, 0, 8'h00, "w3_08");
    access(3, 1, 0, 8'h08, 8'h00, lat_hit, 1, 8'h5A, "r3_08");
    access(3, 1, 0, 8'h09, 8'h00, 4, 0, 8'h00, "r3_09");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
